// File: rtl/multi_dsp_sched.sv
// 54x54 unsigned multiplier built on one shared 27x18 pipelined slice.
// It issues six partial products in order, then shift-accumulates them into a 108-bit result.
module multi_dsp_sched #(
    parameter int unsigned RADIX   = 54,
    parameter int unsigned DSP_LAT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADIX-1:0]   a,
    input  logic [RADIX-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*RADIX-1:0] res,
    output logic               busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [2:0]         k_q, k_d;
    logic [RADIX-1:0]   a_q, b_q;
    logic [2*RADIX-1:0] acc_q, acc_d;

    logic               mul_i;
    logic [1:0]         mul_j;
    logic [26:0]        mul_a;
    logic [17:0]        mul_b;
    logic [44:0]        mul_p;
    logic               issue;

    // Each pipeline word is {i, j[1:0], product[44:0]}. Stage 0 is the newest.
    logic [DSP_LAT-1:0]        pv_q;
    logic [DSP_LAT:0]          pv_sh;
    logic [DSP_LAT-1:0][47:0]  pd_q;
    logic [DSP_LAT:0][47:0]    pd_sh;
    logic [47:0]               last;
    logic [6:0]                shamt;
    logic [2*RADIX-1:0]        addend;

    assign issue = (state_q == StIssue);

    always_comb begin
        mul_i = 1'b0;
        mul_j = 2'd0;
        case (k_q)
            3'd1:    mul_j = 2'd1;
            3'd2:    mul_j = 2'd2;
            3'd3:    mul_i = 1'b1;
            3'd4:    begin mul_i = 1'b1; mul_j = 2'd1; end
            3'd5:    begin mul_i = 1'b1; mul_j = 2'd2; end
            default: ;
        endcase
        mul_a = mul_i ? a_q[53:27] : a_q[26:0];
        case (mul_j)
            2'd0:    mul_b = b_q[17:0];
            2'd1:    mul_b = b_q[35:18];
            default: mul_b = b_q[53:36];
        endcase
    end

    assign mul_p = {18'd0, mul_a} * {27'd0, mul_b};

    assign pv_sh = {pv_q, issue};
    assign pd_sh = {pd_q, {mul_i, mul_j, mul_p}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv_q <= '0;
        end else begin
            pv_q <= pv_sh[DSP_LAT-1:0];
        end
    end

    // Pipeline data needs no reset because the valid bits qualify it.
    always_ff @(posedge clk) begin
        pd_q <= pd_sh[DSP_LAT-1:0];
    end

    assign last   = pd_q[DSP_LAT-1];
    assign shamt  = (last[47] ? 7'd27 : 7'd0) + ({5'd0, last[46:45]} * 7'd18);
    assign addend = {63'd0, last[44:0]} << shamt;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        if (pv_q[DSP_LAT-1]) begin
            acc_d = acc_q + addend;
        end
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StIssue;
                    k_d     = 3'd0;
                    acc_d   = '0;
                end
            end
            StIssue: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd5) begin
                    state_d = StDrain;
                    k_d     = 3'd0;
                end
            end
            StDrain: begin
                // The final product has already been added when its valid bit leaves the pipe.
                if (pv_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= 3'd0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StIdle && in_valid) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign res       = acc_q;

endmodule
